// File: rtl/btn_ctrl.sv
// btn_ctrl: front-panel button conditioner.
// Sync, debounce and classify presses into a polled event register.
module btn_ctrl #(
  parameter int N            = 2,
  parameter int DEBOUNCE_CYC = 270000,
  parameter int LONG_CYC     = 27000000,
  parameter int REPEAT_CYC   = 5400000
) (
  input  logic         clk27,
  input  logic         reset,
  input  logic [N-1:0] btn_n,
  output logic [N-1:0] btn_db,
  output logic         evt_valid,
  output logic [2:0]   evt_btn,
  output logic [1:0]   evt_type,
  output logic [7:0]   evt_cnt
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int LW = $clog2(LONG_CYC + 1);
  localparam int RW = (REPEAT_CYC > 0) ? $clog2(REPEAT_CYC + 1) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYC - 1);
  localparam logic [RW-1:0] R_LAST =
    (REPEAT_CYC > 0) ? RW'(REPEAT_CYC - 1) : '0;

  localparam logic [1:0] EV_PRESS  = 2'd0;
  localparam logic [1:0] EV_REL    = 2'd1;
  localparam logic [1:0] EV_LONG   = 2'd2;
  localparam logic [1:0] EV_REPEAT = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic [N-1:0] pend_v;
  logic [1:0]   pend_t [N];
  logic [N-1:0] grant;
  logic         found;
  logic [2:0]   sel_b;
  logic [1:0]   sel_t;

  for (genvar i = 0; i < N; i++) begin : g_btn
    logic          s1_q, s2_q, db_q;
    logic [DW-1:0] dcnt_q;
    logic          differ, toggle, rise, fall;
    state_t        st_q, st_d;
    logic [LW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          raise;
    logic [1:0]    raise_t;
    logic          pv_q;
    logic [1:0]    pt_q;

    assign differ = (~s2_q != db_q);
    assign toggle = differ && (dcnt_q == D_LAST);
    assign rise   = toggle & ~db_q;
    assign fall   = toggle & db_q;

    // two-flop synchroniser and stable-level debounce counter
    always_ff @(posedge clk27) begin
      if (reset) begin
        s1_q   <= 1'b1;
        s2_q   <= 1'b1;
        db_q   <= 1'b0;
        dcnt_q <= '0;
      end else begin
        s1_q <= btn_n[i];
        s2_q <= s1_q;
        if (!differ || toggle) dcnt_q <= '0;
        else                   dcnt_q <= dcnt_q + 1'b1;
        if (toggle) db_q <= ~db_q;
      end
    end

    // classifier state and hold/repeat counters
    always_ff @(posedge clk27) begin
      if (reset) begin
        st_q   <= IDLE;
        hcnt_q <= '0;
        rcnt_q <= '0;
      end else begin
        st_q   <= st_d;
        hcnt_q <= hcnt_d;
        rcnt_q <= rcnt_d;
      end
    end

    // next state and event raise, acting on the edge btn_db changes
    always_comb begin
      st_d    = st_q;
      hcnt_d  = hcnt_q;
      rcnt_d  = rcnt_q;
      raise   = 1'b0;
      raise_t = EV_PRESS;
      unique case (st_q)
        IDLE: begin
          if (rise) begin
            st_d    = PRESSED;
            hcnt_d  = '0;
            raise   = 1'b1;
            raise_t = EV_PRESS;
          end
        end
        PRESSED: begin
          if (fall) begin
            st_d    = IDLE;
            raise   = 1'b1;
            raise_t = EV_REL;
          end else if (hcnt_q == L_LAST) begin
            st_d    = HELD;
            rcnt_d  = '0;
            raise   = 1'b1;
            raise_t = EV_LONG;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            st_d    = IDLE;
            raise   = 1'b1;
            raise_t = EV_REL;
          end else if (REPEAT_CYC != 0) begin
            if (rcnt_q == R_LAST) begin
              rcnt_d  = '0;
              raise   = 1'b1;
              raise_t = EV_REPEAT;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end

    // pending slot; a fresh raise wins over the arbiter drain
    always_ff @(posedge clk27) begin
      if (reset) begin
        pv_q <= 1'b0;
        pt_q <= EV_PRESS;
      end else if (raise) begin
        pv_q <= 1'b1;
        pt_q <= raise_t;
      end else if (grant[i]) begin
        pv_q <= 1'b0;
      end
    end

    assign btn_db[i] = db_q;
    assign pend_v[i] = pv_q;
    assign pend_t[i] = pt_q;
  end

  // lowest-index pending button wins this cycle
  always_comb begin
    grant = '0;
    found = 1'b0;
    sel_b = '0;
    sel_t = EV_PRESS;
    for (int i = 0; i < N; i++) begin
      if (pend_v[i] && !found) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        sel_b    = 3'(i);
        sel_t    = pend_t[i];
      end
    end
  end

  // publish one event per cycle into the polled register
  always_ff @(posedge clk27) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_type  <= '0;
      evt_cnt   <= '0;
    end else begin
      evt_valid <= found;
      if (found) begin
        evt_btn  <= sel_b;
        evt_type <= sel_t;
        evt_cnt  <= evt_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_btn_ctrl.sv
// tb_btn_ctrl: scoreboard bench for btn_ctrl.
// Directed button waveforms, expected events queued with publish cycle.
module tb_btn_ctrl;

  logic       clk27 = 1'b0;
  logic       reset;
  logic [1:0] btn_n;
  logic [1:0] btn_db;
  logic       evt_valid;
  logic [2:0] evt_btn;
  logic [1:0] evt_type;
  logic [7:0] evt_cnt;

  btn_ctrl #(
    .N(2),
    .DEBOUNCE_CYC(8),
    .LONG_CYC(40),
    .REPEAT_CYC(16)
  ) dut (
    .clk27(clk27),
    .reset(reset),
    .btn_n(btn_n),
    .btn_db(btn_db),
    .evt_valid(evt_valid),
    .evt_btn(evt_btn),
    .evt_type(evt_type),
    .evt_cnt(evt_cnt)
  );

  typedef struct {
    int b;
    int ty;
    int cnt;
    int at;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  exp_cnt = 0;

  always #5 clk27 = ~clk27;

  always @(posedge clk27) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk27);
  endtask

  task automatic push(int b, int ty, int at);
    exp_cnt = (exp_cnt + 1) % 256;
    sb.push_back('{b, ty, exp_cnt, at});
  endtask

  task automatic chk_db(int idx, int t, int exp);
    wait_cyc(t);
    chk($sformatf("btn_db[%0d]", idx), int'(btn_db[idx]), exp);
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, " btn_db"}, int'(btn_db), 0);
    chk({tag, " evt_valid"}, int'(evt_valid), 0);
    chk({tag, " evt_btn"}, int'(evt_btn), 0);
    chk({tag, " evt_type"}, int'(evt_type), 0);
    chk({tag, " evt_cnt"}, int'(evt_cnt), 0);
  endtask

  // monitor: pop on every strobe, flag events that never arrived
  always @(negedge clk27) begin
    if (!reset) begin
      if (evt_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected evt_valid", 1, 0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("evt_btn", int'(evt_btn), e.b);
          chk("evt_type", int'(evt_type), e.ty);
          chk("evt_cnt", int'(evt_cnt), e.cnt);
          chk("evt cycle", cyc, e.at);
        end
      end else if (sb.size() != 0 && sb[0].at < cyc) begin
        ev_t e;
        e = sb.pop_front();
        chk("missing evt cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, tp;
    reset = 1'b1;
    btn_n = 2'b11;
    wait_cyc(2);
    chk_reset_state("reset");
    wait_cyc(3);
    reset = 1'b0;

    // press, long, repeats, release on button 0
    t0 = 5;
    wait_cyc(t0);
    btn_n[0] = 1'b0;
    push(0, 0, t0 + 11);
    push(0, 2, t0 + 51);
    push(0, 3, t0 + 67);
    push(0, 3, t0 + 83);
    push(0, 3, t0 + 99);
    push(0, 3, t0 + 115);
    push(0, 1, t0 + 121);
    chk_db(0, t0 + 9, 0);
    chk_db(0, t0 + 10, 1);
    wait_cyc(t0 + 110);
    btn_n[0] = 1'b1;
    chk_db(0, t0 + 119, 1);
    chk_db(0, t0 + 120, 0);

    // bounced press on button 1
    t1 = t0 + 140;
    wait_cyc(t1);
    btn_n[1] = 1'b0;
    wait_cyc(t1 + 5);
    btn_n[1] = 1'b1;
    wait_cyc(t1 + 8);
    btn_n[1] = 1'b0;
    push(1, 0, t1 + 19);
    chk_db(1, t1 + 10, 0);
    chk_db(1, t1 + 17, 0);
    chk_db(1, t1 + 18, 1);
    wait_cyc(t1 + 30);
    btn_n[1] = 1'b1;
    push(1, 1, t1 + 41);

    // simultaneous presses and releases publish in index order
    t2 = t1 + 60;
    wait_cyc(t2);
    btn_n = 2'b00;
    push(0, 0, t2 + 11);
    push(1, 0, t2 + 12);
    wait_cyc(t2 + 20);
    btn_n = 2'b11;
    push(0, 1, t2 + 31);
    push(1, 1, t2 + 32);
    wait_cyc(t2 + 33);
    chk("evt_cnt after pair", int'(evt_cnt), 13);

    // clean reset so the wrap run starts from zero
    wait_cyc(t2 + 40);
    reset = 1'b1;
    wait_cyc(t2 + 41);
    chk_reset_state("reset2");
    reset = 1'b0;
    exp_cnt = 0;

    // 257 press/release pairs wrap the counter to 2
    tp = t2 + 50;
    for (int k = 0; k < 257; k++) begin
      wait_cyc(tp);
      btn_n[0] = 1'b0;
      push(0, 0, tp + 11);
      wait_cyc(tp + 20);
      btn_n[0] = 1'b1;
      push(0, 1, tp + 31);
      tp = tp + 40;
    end
    wait_cyc(tp);
    chk("evt_cnt wrap", int'(evt_cnt), 2);

    // reset while held in HELD: fresh press, no release
    t3 = tp + 10;
    wait_cyc(t3);
    btn_n[0] = 1'b0;
    push(0, 0, t3 + 11);
    push(0, 2, t3 + 51);
    wait_cyc(t3 + 60);
    reset = 1'b1;
    wait_cyc(t3 + 61);
    chk_reset_state("reset mid-press");
    chk("queue drained at reset", sb.size(), 0);
    reset = 1'b0;
    exp_cnt = 0;
    push(0, 0, t3 + 72);
    chk_db(0, t3 + 70, 0);
    chk_db(0, t3 + 71, 1);
    wait_cyc(t3 + 80);
    btn_n[0] = 1'b1;
    push(0, 1, t3 + 91);
    wait_cyc(t3 + 120);
    chk("queue empty at end", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
